// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Next-level memory model behind the L1 cache. It accepts one request at a
//   time over a valid/ready channel, then answers a fixed LATENCY cycles later
//   over a second valid/ready channel. Storage is word addressed and wraps
//   modulo 2**DEPTH_LOG2 words.
//
// Parameters
//   ADDR_W      request byte-address width
//   DATA_W      data word width
//   DEPTH_LOG2  log2 of the backing-store word count
//   LATENCY     acceptance-to-rsp_valid delay in cycles, legal range 1..15
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  request can be accepted
//   req_wr     0 = read, 1 = write        req_addr   byte address
//   req_wdata  write data
//   rsp_valid  response present           rsp_ready  response consumed
//   rsp_rdata  read data (0 for writes)   rsp_wr     req_wr of this response
//   rd_count   accepted reads             wr_count   accepted writes
//
// Build option
//   MEM_RESP_PERF_EN  when defined, rd_count/wr_count are saturating 16-bit
//                     counters cleared by reset; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_wr,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 32'sd1);
   localparam bit         LAT_ONE  = (LATENCY == 32'sd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [3:0]              lat_cnt_r;
   logic                    live_r;
   logic                    accept_s;
   logic [DEPTH_LOG2-1:0]   idx_s;
   logic [DATA_W-1:0]       mem_r [DEPTH];
   logic [DATA_W-1:0]       rdata_r;
   logic                    rsp_wr_r;
   logic                    unused_addr_s;

   // Words are stored XOR-ed with their own index. Storage powers up all-zero,
   // so an unwritten word reads back as its index (mem[i] = i) without any
   // initialisation pass; the mapping is its own inverse.
   function automatic logic [DATA_W-1:0] word_code(
      input logic [DATA_W-1:0]     data,
      input logic [DEPTH_LOG2-1:0] idx
   );
      return data ^ DATA_W'(idx);
   endfunction

   assign idx_s         = req_addr[DEPTH_LOG2+1:2];
   assign unused_addr_s = ^{req_addr[ADDR_W-1:DEPTH_LOG2+2], req_addr[1:0]};
   assign accept_s      = req_valid & req_ready;
   assign rsp_rdata     = rdata_r;
   assign rsp_wr        = rsp_wr_r;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = LAT_ONE ? ST_RESP : ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_r == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from registered state only.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_r)
         ST_IDLE: req_ready = live_r;
         ST_WAIT: req_ready = 1'b0;
         ST_RESP: rsp_valid = 1'b1;
         default: begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
         end
      endcase
   end

   // Holds req_ready low through reset and releases it one edge later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live_r <= 1'b0;
      end else begin
         live_r <= 1'b1;
      end
   end

   // Latency down-counter: loaded on acceptance, counts down while waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_cnt_r <= 4'd0;
      end else if (accept_s) begin
         lat_cnt_r <= LAT_LOAD;
      end else if ((state_r == ST_WAIT) && (lat_cnt_r != 4'd0)) begin
         lat_cnt_r <= lat_cnt_r - 4'd1;
      end else begin
         lat_cnt_r <= lat_cnt_r;
      end
   end

   // Response payload captured at acceptance and held until the next one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_r  <= '0;
         rsp_wr_r <= 1'b0;
      end else if (accept_s) begin
         rsp_wr_r <= req_wr;
         rdata_r  <= req_wr ? {DATA_W{1'b0}} : word_code(mem_r[idx_s], idx_s);
      end else begin
         rdata_r  <= rdata_r;
         rsp_wr_r <= rsp_wr_r;
      end
   end

   // Backing store write port; deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (accept_s && req_wr) begin
         mem_r[idx_s] <= word_code(req_wdata, idx_s);
      end
   end

`ifdef MEM_RESP_PERF_EN
   logic [15:0] rd_cnt_r;
   logic [15:0] wr_cnt_r;

   // Saturating counters of accepted reads and writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_r <= 16'd0;
         wr_cnt_r <= 16'd0;
      end else if (accept_s) begin
         if (req_wr) begin
            wr_cnt_r <= (wr_cnt_r == 16'hFFFF) ? wr_cnt_r : wr_cnt_r + 16'd1;
         end else begin
            rd_cnt_r <= (rd_cnt_r == 16'hFFFF) ? rd_cnt_r : rd_cnt_r + 16'd1;
         end
      end else begin
         rd_cnt_r <= rd_cnt_r;
         wr_cnt_r <= wr_cnt_r;
      end
   end

   assign rd_count = rd_cnt_r;
   assign wr_count = wr_cnt_r;
`else
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int LAT = 3;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_wr    = 1'b0;
   logic [31:0] req_addr  = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_wr;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   mem_responder #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] mdl_mem [1024];
   int unsigned rd_m = 0;
   int unsigned wr_m = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_wr;
   } vec_t;

   vec_t vecs [8];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: a flat word array plus transaction counts.
   task automatic model_apply(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp);
      int idx;
      idx = int'(addr[11:2]);
      if (wr) begin
         mdl_mem[idx] = wdata;
         exp = 32'd0;
         if (wr_m < 32'hFFFF) wr_m++;
      end else begin
         exp = mdl_mem[idx];
         if (rd_m < 32'hFFFF) rd_m++;
      end
   endtask

   // One full request/response transaction; lat counts edges from acceptance
   // to the first cycle rsp_valid is seen.
   task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input bit poke,
                      output logic [31:0] rdata, output bit rwr, output int lat);
      int n;
      n = 0; lat = -1; rdata = 32'd0; rwr = 1'b0;
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 30) begin tick; n++; end
      if (!req_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      tick;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      lat = 0;
      while (!rsp_valid && lat < 30) begin tick; lat++; end
      if (!rsp_valid) begin
         chk("rsp_timeout", 64'd0, 64'd1);
         return;
      end
      rdata = rsp_rdata;
      rwr   = rsp_wr;
      for (int h = 0; h < hold; h++) begin
         if (poke && h == 1) begin
            req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'd0; req_wdata = 32'hFFFF_FFFF;
         end
         tick;
         req_valid = 1'b0; req_wr = 1'b0; req_wdata = 32'd0;
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_rdata", 64'(rsp_rdata), 64'(rdata));
         chk("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
      chk("ready_back", 64'(req_ready), 64'd1);
   endtask

   task automatic check_counters(input string nm);
`ifdef MEM_RESP_PERF_EN
      chk({nm, "_rd"}, 64'(rd_count), 64'(rd_m));
      chk({nm, "_wr"}, 64'(wr_count), 64'(wr_m));
`else
      chk({nm, "_rd"}, 64'(rd_count), 64'd0);
      chk({nm, "_wr"}, 64'(wr_count), 64'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, exp;
      bit          rw;
      int          lat;

      for (int i = 0; i < 1024; i++) mdl_mem[i] = 32'(i);

      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0004, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[2] = '{1'b0, 32'h0000_0043, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_1004, 32'h0,         32'h0000_0001, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_03FF, 1'b0};
      vecs[5] = '{1'b1, 32'h1000_0044, 32'h0000_A5A5, 32'h0000_0000, 1'b1};
      vecs[6] = '{1'b0, 32'h0000_0046, 32'h0,         32'h0000_A5A5, 1'b0};
      vecs[7] = '{1'b0, 32'hFFFF_F048, 32'h0,         32'h0000_0012, 1'b0};

      // Reset state
      repeat (3) tick;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_rsp_wr",    64'(rsp_wr),    64'd0);
      check_counters("rst_cnt");
      #3 reset = 1'b1;
      tick;
      chk("post_rst_ready", 64'(req_ready), 64'd1);

      // rsp_ready outside RESP is ignored
      rsp_ready = 1'b1;
      repeat (2) tick;
      chk("idle_rsp_ready_valid", 64'(rsp_valid), 64'd0);
      chk("idle_rsp_ready_ready", 64'(req_ready), 64'd1);
      rsp_ready = 1'b0;

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp);
         txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 1'b0, rd, rw, lat);
         chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
         chk($sformatf("vec%0d_wr", i), 64'(rw), 64'(vecs[i].exp_wr));
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      end

      // Stall in RESP for 5 cycles with an ignored request poke
      model_apply(1'b0, 32'h0000_0020, 32'd0, exp);
      txn(1'b0, 32'h0000_0020, 32'd0, 5, 1'b1, rd, rw, lat);
      chk("hold_read_data", 64'(rd), 64'(exp));
      model_apply(1'b0, 32'h0000_0000, 32'd0, exp);
      txn(1'b0, 32'h0000_0000, 32'd0, 0, 1'b0, rd, rw, lat);
      chk("poke_ignored", 64'(rd), 64'(exp));

      // Reset during WAIT after a write
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_0008; req_wdata = 32'h1234_5678;
      chk("mid_rst_ready_pre", 64'(req_ready), 64'd1);
      tick;
      req_valid = 1'b0; req_wr = 1'b0;
      tick;
      reset = 1'b0;
      mdl_mem[2] = 32'h1234_5678;
      rd_m = 0; wr_m = 0;
      #1;
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      repeat (2) tick;
      #3 reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("after_rst_valid", 64'(rsp_valid), 64'd0);
      end
      chk("after_rst_ready", 64'(req_ready), 64'd1);
      check_counters("after_rst_cnt");

      // Committed write survives; then 3 reads / 2 writes for the counters
      model_apply(1'b0, 32'h0000_0008, 32'd0, exp);
      txn(1'b0, 32'h0000_0008, 32'd0, 0, 1'b0, rd, rw, lat);
      chk("rst_write_kept", 64'(rd), 64'h1234_5678);
      model_apply(1'b0, 32'h0000_0004, 32'd0, exp);
      txn(1'b0, 32'h0000_0004, 32'd0, 0, 1'b0, rd, rw, lat);
      chk("cnt_rd2", 64'(rd), 64'(exp));
      model_apply(1'b1, 32'h0000_0100, 32'hCAFE_0001, exp);
      txn(1'b1, 32'h0000_0100, 32'hCAFE_0001, 0, 1'b0, rd, rw, lat);
      model_apply(1'b1, 32'h0000_0104, 32'hCAFE_0002, exp);
      txn(1'b1, 32'h0000_0104, 32'hCAFE_0002, 0, 1'b0, rd, rw, lat);
      model_apply(1'b0, 32'h0000_0100, 32'd0, exp);
      txn(1'b0, 32'h0000_0100, 32'd0, 0, 1'b0, rd, rw, lat);
      chk("cnt_rd3", 64'(rd), 64'(exp));
      check_counters("cnt_3r2w");

      // Randomised traffic against the model
      for (int t = 0; t < 60; t++) begin
         bit          w;
         logic [31:0] a, d;
         int          hold;
         w    = 1'($urandom_range(0, 1));
         a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
         d    = $urandom;
         hold = $urandom_range(0, 3);
         model_apply(w, a, d, exp);
         txn(w, a, d, hold, 1'b0, rd, rw, lat);
         chk($sformatf("rnd%0d_rdata", t), 64'(rd), 64'(exp));
         chk($sformatf("rnd%0d_wr", t), 64'(rw), 64'(w));
         chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(LAT));
      end
      check_counters("final_cnt");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
